// File: rtl/ofdm_pkg.sv
// Shared types and default sizing for the OFDM cyclic-prefix inserter.
// The runtime prefix length feature is selected with OFDM_CP_RUNTIME_LEN_EN.
package ofdm_pkg;

   localparam int DATA_SIZE_DEF    = 16;
   localparam int SYMBOLS_SIZE_DEF = 256;
   localparam int CP_MAX_DEF       = 64;

   localparam int ADDR_W = $clog2(SYMBOLS_SIZE_DEF);
   localparam int CP_W   = $clog2(CP_MAX_DEF + 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   typedef struct packed {
      logic [DATA_SIZE_DEF-1:0] i;
      logic [DATA_SIZE_DEF-1:0] q;
   } sample_t;

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank symbol store: one write port, one registered read port; the bank bit is the address MSB.
// The read register holds its value when no read is issued, so it doubles as the output stage.
module ofdm_pingpong_ram
   import ofdm_pkg::*;
#(
   parameter int DATA_SIZE    = DATA_SIZE_DEF,
   parameter int SYMBOLS_SIZE = SYMBOLS_SIZE_DEF,
   parameter int AW           = $clog2(SYMBOLS_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en_i,
   input  logic [AW:0]            wr_addr_i,
   input  logic [2*DATA_SIZE-1:0] wr_data_i,
   input  logic                   rd_en_i,
   input  logic [AW:0]            rd_addr_i,
   output logic [2*DATA_SIZE-1:0] rd_data_o
);

   logic [2*DATA_SIZE-1:0] mem_q [2*SYMBOLS_SIZE];
   logic [2*DATA_SIZE-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter with a ping-pong symbol buffer and valid/ready on both sides.
// Define OFDM_CP_RUNTIME_LEN_EN to add the per-symbol cp_len input (clamped to CP_MAX).
module ofdm_cp_inserter
   import ofdm_pkg::*;
#(
   parameter int DATA_SIZE    = DATA_SIZE_DEF,
   parameter int SYMBOLS_SIZE = SYMBOLS_SIZE_DEF,
   parameter int CP_MAX       = CP_MAX_DEF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_data_en,
   output logic                           o_in_ready,
   input  logic [DATA_SIZE-1:0]           in_data_i,
   input  logic [DATA_SIZE-1:0]           in_data_q,
`ifdef OFDM_CP_RUNTIME_LEN_EN
   input  logic [$clog2(CP_MAX+1)-1:0]    cp_len,
`endif
   output logic                           output_en,
   input  logic                           i_out_ready,
   output logic [DATA_SIZE-1:0]           out_data_i,
   output logic [DATA_SIZE-1:0]           out_data_q,
   output logic                           out_sof,
   output logic                           out_eof
);

   localparam int AW = $clog2(SYMBOLS_SIZE);
   localparam int CW = $clog2(CP_MAX + 1);
   localparam int NW = $clog2(SYMBOLS_SIZE + CP_MAX);

   typedef struct packed {
      logic [DATA_SIZE-1:0] i;
      logic [DATA_SIZE-1:0] q;
   } iq_t;

   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic [1:0]    full_q, full_d;
   state_e        state_q, state_d;
   logic          rd_bank_q, rd_bank_d;
   logic [NW-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0] len_q, len_d;
   logic          valid_q, valid_d;
   logic          sof_q, sof_d;
   logic          eof_q, eof_d;

   logic          wr_fire;
   logic          rd_fire;
   logic          rd_last;
   logic [CW-1:0] len_eff;
   logic [NW-1:0] last_idx;
   logic [AW-1:0] rd_addr;
   iq_t           wr_sample;
   iq_t           rd_sample;

`ifdef OFDM_CP_RUNTIME_LEN_EN
   assign len_eff = (cp_len > CW'(CP_MAX)) ? CW'(CP_MAX) : cp_len;
`else
   assign len_eff = CW'(CP_MAX);
`endif

   assign o_in_ready = !full_q[wr_bank_q];
   assign wr_fire    = in_data_en && o_in_ready;
   assign rd_fire    = (state_q == SEND) && (!valid_q || i_out_ready);
   assign last_idx   = NW'(SYMBOLS_SIZE) + NW'(len_q) - NW'(1);
   assign rd_last    = rd_fire && (rd_idx_q == last_idx);
   assign wr_sample  = {in_data_i, in_data_q};

   // Prefix samples come from the tail of the stored symbol, then the body from address 0.
   always_comb begin
      rd_addr = '0;
      if (rd_idx_q < NW'(len_q)) begin
         rd_addr = AW'(NW'(SYMBOLS_SIZE) - NW'(len_q) + rd_idx_q);
      end else begin
         rd_addr = AW'(rd_idx_q - NW'(len_q));
      end
   end

   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      full_d    = full_q;
      state_d   = state_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      len_d     = len_q;
      valid_d   = valid_q;
      sof_d     = sof_q;
      eof_d     = eof_q;

      if (wr_fire) begin
         if (wr_idx_q == AW'(SYMBOLS_SIZE - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end

      // The prefix length is frozen here for the whole symbol.
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = SEND;
               len_d    = len_eff;
               rd_idx_d = '0;
            end
         end
         SEND: begin
            if (rd_fire) begin
               if (rd_last) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = !rd_bank_q;
                  state_d           = IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_fire) begin
         valid_d = 1'b1;
         sof_d   = (rd_idx_q == '0);
         eof_d   = rd_last;
      end else if (i_out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         full_q    <= '0;
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         len_q     <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_idx_q  <= wr_idx_d;
         full_q    <= full_d;
         state_q   <= state_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
         len_q     <= len_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
      end
   end

   ofdm_pingpong_ram #(
      .DATA_SIZE    (DATA_SIZE),
      .SYMBOLS_SIZE (SYMBOLS_SIZE),
      .AW           (AW)
   ) u_ram (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_fire),
      .wr_addr_i ({wr_bank_q, wr_idx_q}),
      .wr_data_i (wr_sample),
      .rd_en_i   (rd_fire),
      .rd_addr_i ({rd_bank_q, rd_addr}),
      .rd_data_o (rd_sample)
   );

   assign output_en  = valid_q;
   assign out_sof    = sof_q;
   assign out_eof    = eof_q;
   assign out_data_i = rd_sample.i;
   assign out_data_q = rd_sample.q;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Directed bench for ofdm_cp_inserter with SYMBOLS_SIZE=16, CP_MAX=4.
// The cp_len sweep runs only when OFDM_CP_RUNTIME_LEN_EN is defined.
module tb_ofdm_cp_inserter;

   localparam int DW  = 16;
   localparam int NS  = 16;
   localparam int CPM = 4;
   localparam int CW  = $clog2(CPM + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_data_en = 1'b0;
   logic          i_out_ready = 1'b1;
   logic [DW-1:0] in_data_i = '0;
   logic [DW-1:0] in_data_q = '0;
`ifdef OFDM_CP_RUNTIME_LEN_EN
   logic [CW-1:0] cp_len = '0;
`endif
   logic          o_in_ready;
   logic          output_en;
   logic          out_sof;
   logic          out_eof;
   logic [DW-1:0] out_data_i;
   logic [DW-1:0] out_data_q;

   always #5 clk = ~clk;

   ofdm_cp_inserter #(
      .DATA_SIZE    (DW),
      .SYMBOLS_SIZE (NS),
      .CP_MAX       (CPM)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_data_en  (in_data_en),
      .o_in_ready  (o_in_ready),
      .in_data_i   (in_data_i),
      .in_data_q   (in_data_q),
`ifdef OFDM_CP_RUNTIME_LEN_EN
      .cp_len      (cp_len),
`endif
      .output_en   (output_en),
      .i_out_ready (i_out_ready),
      .out_data_i  (out_data_i),
      .out_data_q  (out_data_q),
      .out_sof     (out_sof),
      .out_eof     (out_eof)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] inQ[$];
   logic [33:0] expQ[$];

   int cycle = 0;
   int lastAcceptEdge = -1;
   int firstRise = -1;
   int takes = 0;
   int validCycles = 0;
   int maxGap = 0;
   int gapRun = 0;
   int stallIn = 0;
   int symIn = 0;
   int symOut = 0;
   int inCnt = 0;
   bit stallMode = 1'b0;
   bit pauseIn = 1'b0;
   bit prevHold = 1'b0;
   logic [33:0] prevObs = '0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Queue one ramp symbol on the input and its prefixed image on the expected output.
   task automatic pushSymbol(input int base, input int len);
      logic [15:0] v;
      int idx;
      for (int k = 0; k < NS; k++) begin
         v = 16'(base + k);
         inQ.push_back({v, v ^ 16'hA5A5});
      end
      for (int k = 0; k < NS + len; k++) begin
         idx = (k < len) ? (NS - len + k) : (k - len);
         v = 16'(base + idx);
         expQ.push_back({(k == 0), (k == NS + len - 1), v, v ^ 16'hA5A5});
      end
   endtask

   task automatic resetStats();
      lastAcceptEdge = -1;
      firstRise = -1;
      takes = 0;
      validCycles = 0;
      maxGap = 0;
      gapRun = 0;
      stallIn = 0;
   endtask

   // One clock cycle: drive inputs, check the visible output, then advance past the edge.
   task automatic applyStimulus();
      logic [33:0] obs;
      bit accept;
      bit take;
      i_out_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inQ.size() > 0 && !pauseIn) begin
         in_data_en = 1'b1;
         {in_data_i, in_data_q} = inQ[0];
      end else begin
         in_data_en = 1'b0;
      end
      accept = in_data_en && o_in_ready;
      if (in_data_en && !o_in_ready) stallIn++;
      obs = {out_sof, out_eof, out_data_i, out_data_q};

      if (prevHold) checkOutput("stall_hold", 64'(obs), 64'(prevObs));
      if (output_en) begin
         validCycles++;
         if (firstRise < 0) firstRise = cycle;
         if (gapRun > maxGap) maxGap = gapRun;
         gapRun = 0;
         if (expQ.size() > 0) checkOutput("out_sample", 64'(obs), 64'(expQ[0]));
         else checkOutput("spurious_out", 64'(output_en), 64'(0));
      end else if (firstRise >= 0 && expQ.size() > 0) begin
         gapRun++;
      end

      if (symIn - symOut < 2) checkOutput("in_ready_free", 64'(o_in_ready), 64'(1));
      if (!o_in_ready) checkOutput("in_ready_full", 64'(symIn - symOut), 64'(2));

      prevHold = output_en && !i_out_ready;
      prevObs = obs;
      take = output_en && i_out_ready;

      @(posedge clk);
      #1;
      cycle++;
      if (accept) begin
         void'(inQ.pop_front());
         inCnt++;
         lastAcceptEdge = cycle;
         if (inCnt % NS == 0) symIn++;
      end
      if (take && expQ.size() > 0) begin
         takes++;
         if (expQ[0][32]) symOut++;
         void'(expQ.pop_front());
      end
   endtask

   task automatic runUntilDrained(input int maxCycles, input string tag);
      int n = 0;
      while ((inQ.size() > 0 || expQ.size() > 0 || output_en) && n < maxCycles) begin
         applyStimulus();
         n++;
      end
      checkOutput({tag, "_drained"}, 64'(inQ.size() + expQ.size()), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int n;
      int target;
      $display("[TB] start");

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", 64'({output_en, out_sof, out_eof, out_data_i, out_data_q}), 64'(0));
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 64'(o_in_ready), 64'(1));

      // Single ramp symbol, no back-pressure.
      resetStats();
      pushSymbol(0, CPM);
      runUntilDrained(200, "t1");
      checkOutput("t1_count", 64'(takes), 64'(NS + CPM));
      checkOutput("t1_valid_cycles", 64'(validCycles), 64'(NS + CPM));
      checkOutput("t1_latency", 64'(firstRise - lastAcceptEdge), 64'(2));

      // Three back-to-back symbols with continuous input.
      resetStats();
      pushSymbol(16'h200, CPM);
      pushSymbol(16'h300, CPM);
      pushSymbol(16'h400, CPM);
      runUntilDrained(400, "t2");
      checkOutput("t2_count", 64'(takes), 64'(3 * (NS + CPM)));
      checkOutput("t2_gap", 64'(maxGap <= 1), 64'(1));
      checkOutput("t2_backpressure", 64'(stallIn > 0), 64'(1));

`ifdef OFDM_CP_RUNTIME_LEN_EN
      // Per-symbol prefix lengths, the last one above CP_MAX.
      cp_len = 3'd0;
      resetStats();
      pushSymbol(16'h500, 0);
      runUntilDrained(200, "t3a");
      checkOutput("t3_len0_count", 64'(takes), 64'(16));
      cp_len = 3'd2;
      resetStats();
      pushSymbol(16'h520, 2);
      runUntilDrained(200, "t3b");
      checkOutput("t3_len2_count", 64'(takes), 64'(18));
      cp_len = 3'd7;
      resetStats();
      pushSymbol(16'h540, 4);
      runUntilDrained(200, "t3c");
      checkOutput("t3_len7_count", 64'(takes), 64'(20));
      cp_len = 3'd4;
`endif

      // Random downstream stalls.
      stallMode = 1'b1;
      resetStats();
      pushSymbol(16'h580, CPM);
      pushSymbol(16'h5C0, CPM);
      runUntilDrained(1000, "t4");
      stallMode = 1'b0;
      checkOutput("t4_count", 64'(takes), 64'(2 * (NS + CPM)));

      // Reset in the middle of an outgoing symbol.
      resetStats();
      pushSymbol(16'h600, CPM);
      n = 0;
      while (takes < 9 && n < 200) begin
         applyStimulus();
         n++;
      end
      checkOutput("t5_reached_sample9", 64'(takes), 64'(9));
      #1 reset_n = 1'b0;
      #1;
      checkOutput("t5_async_reset", 64'({output_en, out_sof, out_eof, out_data_i, out_data_q}), 64'(0));
      inQ.delete();
      expQ.delete();
      in_data_en = 1'b0;
      inCnt = 0;
      symIn = 0;
      symOut = 0;
      prevHold = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t5_in_ready_after", 64'(o_in_ready), 64'(1));
      resetStats();
      pushSymbol(16'h700, CPM);
      runUntilDrained(200, "t5");
      checkOutput("t5_count", 64'(takes), 64'(NS + CPM));

      // Input pause in the middle of a symbol.
      resetStats();
      pushSymbol(16'h800, CPM);
      target = inCnt + 8;
      n = 0;
      while (inCnt < target && n < 100) begin
         applyStimulus();
         n++;
      end
      pauseIn = 1'b1;
      repeat (5) begin
         applyStimulus();
         checkOutput("t6_no_early_out", 64'(output_en), 64'(0));
      end
      pauseIn = 1'b0;
      runUntilDrained(200, "t6");
      checkOutput("t6_count", 64'(takes), 64'(NS + CPM));
      checkOutput("t6_latency", 64'(firstRise - lastAcceptEdge), 64'(2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
